// File: rtl/spi_frame_seq.sv
// spi_frame_seq: table-driven single-lane SPI master, one chip-select frame per stored word
// Ports: clk, RST (synchronous, active-high); wr_en/wr_addr/wr_data host table write port;
//        start/mode/stop sequence control; busy/word_done/cur_idx status;
//        spi_cs (active low), spi_clk, spi_data (MOSI) SPI master outputs. All outputs registered.
module spi_frame_seq #(
    parameter int WIDTH     = 24,
    parameter int DEPTH     = 4,
    parameter int DIV       = 4,
    parameter int GAP       = 2,
    parameter bit CPOL      = 1'b0,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic                     clk,
    input  logic                     RST,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     start,
    input  logic                     mode,
    input  logic                     stop,
    output logic                     busy,
    output logic                     word_done,
    output logic [$clog2(DEPTH)-1:0] cur_idx,
    output logic                     spi_cs,
    output logic                     spi_clk,
    output logic                     spi_data
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DIV + 1);
    localparam int GW = $clog2(GAP + 1);
    localparam int TW = $clog2(2 * WIDTH + 1);
    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, GAP_WAIT} state_t;
    state_t           state;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] sh;
    logic [CW-1:0]    cnt;
    logic [GW-1:0]    gcnt;
    logic [TW-1:0]    tog;
    logic             mode_r;
    logic             stop_l;
    logic [AW-1:0]    nxt_idx;
    logic [WIDTH-1:0] nxt_word;
    logic             halt;
    function automatic logic first_bit(input logic [WIDTH-1:0] w);
        return LSB_FIRST ? w[0] : w[WIDTH-1];
    endfunction
    always_comb begin
        nxt_idx  = cur_idx + AW'(1);
        nxt_word = mem[nxt_idx];
        halt     = stop_l || (!mode_r && cur_idx == AW'(DEPTH - 1));
    end
    always_ff @(posedge clk)
        if (RST)
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        else if (wr_en)
            mem[wr_addr] <= wr_data;
    // tog counts completed spi_clk toggles; an odd count before a toggle means it is a trailing edge
    always_ff @(posedge clk) begin
        if (RST) begin
            state     <= IDLE;
            sh        <= '0;
            cnt       <= '0;
            gcnt      <= '0;
            tog       <= '0;
            mode_r    <= 1'b0;
            stop_l    <= 1'b0;
            busy      <= 1'b0;
            word_done <= 1'b0;
            cur_idx   <= '0;
            spi_cs    <= 1'b1;
            spi_clk   <= CPOL;
            spi_data  <= 1'b0;
        end else begin
            word_done <= 1'b0;
            if (busy && stop) stop_l <= 1'b1;
            case (state)
                IDLE: if (start) begin
                    state    <= SETUP;
                    cur_idx  <= '0;
                    mode_r   <= mode;
                    stop_l   <= stop;
                    busy     <= 1'b1;
                    sh       <= mem[0];
                    cnt      <= '0;
                    spi_cs   <= 1'b0;
                    spi_data <= first_bit(mem[0]);
                end
                SETUP: begin
                    cnt <= (cnt == CW'(DIV - 1)) ? '0 : cnt + 1'b1;
                    tog <= '0;
                    if (cnt == CW'(DIV - 1)) state <= SHIFT;
                end
                SHIFT: if (cnt != CW'(DIV - 1)) cnt <= cnt + 1'b1;
                else begin
                    cnt     <= '0;
                    spi_clk <= ~spi_clk;
                    tog     <= tog + 1'b1;
                    if (tog[0]) begin
                        sh       <= LSB_FIRST ? sh >> 1 : sh << 1;
                        spi_data <= LSB_FIRST ? sh[1] : sh[WIDTH-2];
                    end
                    if (tog == TW'(2 * WIDTH - 1)) begin
                        state     <= GAP_WAIT;
                        gcnt      <= '0;
                        spi_cs    <= 1'b1;
                        spi_data  <= 1'b0;
                        word_done <= 1'b1;
                    end
                end
                GAP_WAIT: if (gcnt != GW'(GAP - 1)) gcnt <= gcnt + 1'b1;
                else if (halt) begin
                    state  <= IDLE;
                    busy   <= 1'b0;
                    stop_l <= 1'b0;
                end else begin
                    state    <= SETUP;
                    cur_idx  <= nxt_idx;
                    sh       <= nxt_word;
                    cnt      <= '0;
                    spi_cs   <= 1'b0;
                    spi_data <= first_bit(nxt_word);
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
